// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the iterative mul/div unit.
// Handshake: the EX stage holds StartE with stable operands while it sees BusyE;
// the operation is accepted on the first rising edge where the unit is idle,
// StartE=1 and FlushE=0, and the result is valid for the single cycle DoneE=1.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            FlushE;
    logic            StartE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] ResultE;

    modport master (
        output FlushE, StartE, funct3E, SrcAE, SrcBE,
        input  BusyE, DoneE, ResultE
    );

    modport slave (
        input  FlushE, StartE, funct3E, SrcAE, SrcBE,
        output BusyE, DoneE, ResultE
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fixed up at the end.
// Divide-by-zero and signed overflow bypass the iteration and finish at once.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_muldiv_unit_if.slave      bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_hi;      // product high half / partial remainder
    logic [XLEN-1:0]  r_lo;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]  r_b;       // multiplicand / divisor magnitude
    logic [2:0]       r_f3;
    logic             r_neg;     // result must be negated at the end
    logic             r_done;
    logic [XLEN-1:0]  r_result;

    // Capture-time decode
    logic [2:0]       w_f3;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic             w_sa;
    logic             w_sb;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic             w_neg;
    logic             w_div0;
    logic             w_ovf;
    logic [XLEN-1:0]  w_special_res;
    logic             w_start;

    assign w_f3    = bus.funct3E;
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
    // MUL low bits do not depend on signedness, so it runs unsigned.
    assign w_a_sgn = (w_f3 == 3'b001) | (w_f3 == 3'b010) | (w_f3 == 3'b100) | (w_f3 == 3'b110);
    assign w_b_sgn = (w_f3 == 3'b001) | (w_f3 == 3'b100) | (w_f3 == 3'b110);
    assign w_sa    = w_a_sgn & bus.SrcAE[XLEN-1];
    assign w_sb    = w_b_sgn & bus.SrcBE[XLEN-1];
    assign w_mag_a = w_sa ? (-bus.SrcAE) : bus.SrcAE;
    assign w_mag_b = w_sb ? (-bus.SrcBE) : bus.SrcBE;
    // Remainder takes the dividend's sign; everything else takes sA^sB.
    assign w_neg   = (w_f3 == 3'b110) ? w_sa : (w_sa ^ w_sb);

    assign w_div0  = w_f3[2] & (bus.SrcBE == '0);
    assign w_ovf   = w_f3[2] & ~w_f3[0] &
                     (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (bus.SrcBE == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = w_f3[1] ? bus.SrcAE : '1;
        else if (w_ovf)
            w_special_res = w_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    assign w_start = (r_state == S_IDLE) & bus.StartE & ~bus.FlushE;

    // Iteration datapath
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_sub;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_nxt_hi;
    logic [XLEN-1:0]   w_nxt_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    // Partial remainder < divisor, so the sign of this subtraction is bit XLEN.
    assign w_div_sub   = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = ~w_div_sub[XLEN];

    assign w_nxt_hi = r_f3[2] ? (w_div_ge ? w_div_sub[XLEN-1:0] : w_div_shift[XLEN-1:0])
                              : w_mul_sum[XLEN:1];
    assign w_nxt_lo = r_f3[2] ? {r_lo[XLEN-2:0], w_div_ge}
                              : {w_mul_sum[0], r_lo[XLEN-1:1]};

    assign w_prod = r_neg ? (-{w_nxt_hi, w_nxt_lo}) : {w_nxt_hi, w_nxt_lo};
    assign w_quo  = r_neg ? (-w_nxt_lo) : w_nxt_lo;
    assign w_rem  = r_neg ? (-w_nxt_hi) : w_nxt_hi;

    always_comb begin
        w_final = '0;
        if (r_f3[2])
            w_final = r_f3[1] ? w_rem : w_quo;
        else if (r_f3[1:0] == 2'b00)
            w_final = w_prod[XLEN-1:0];
        else
            w_final = w_prod[2*XLEN-1:XLEN];
    end

    // Control FSM with datapath registers and registered DoneE/ResultE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_hi  <= '0;
                        r_lo  <= w_mag_a;
                        r_b   <= w_mag_b;
                        r_f3  <= w_f3;
                        r_neg <= w_neg;
                        r_cnt <= '0;
                        if (w_div0 | w_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.FlushE) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi  <= w_nxt_hi;
                        r_lo  <= w_nxt_lo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(XLEN-1)) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall request is combinational so the capture cycle itself stalls.
    assign bus.BusyE   = reset & (((r_state == S_IDLE) & bus.StartE & ~bus.FlushE) |
                                  (r_state == S_BUSY));
    assign bus.DoneE   = r_done;
    assign bus.ResultE = r_result;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vectors with hand-computed results,
// scoreboard queue filled at issue and drained by a DoneE monitor.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc = 0;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000ns");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              busy_q[$];
  int              issue_q[$];
  string           name_q[$];

  int              n_tests = 0;
  int              n_fail  = 0;
  logic [XLEN-1:0] last_result = '0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int   busy_run  = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.FlushE) busy_run = 0;
      else if (bus.BusyE) busy_run++;
      if (prev_done) check("done_single_pulse", {31'b0, bus.DoneE}, 32'd0);
      if (bus.DoneE) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got DoneE=1 result 0x%08h, expected no DoneE", bus.ResultE);
        end else begin
          logic [XLEN-1:0] e;
          int    l, b, s;
          string nm;
          e  = exp_q.pop_front();
          l  = lat_q.pop_front();
          b  = busy_q.pop_front();
          s  = issue_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_result"}, bus.ResultE, e);
          check_int({nm, "_latency"}, cyc - s, l);
          check_int({nm, "_busy_cycles"}, busy_run, b);
        end
        busy_run = 0;
      end
      prev_done = bus.DoneE;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input string name, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input bit track);
    @(posedge clk); #1;
    bus.funct3E = f3;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    bus.StartE  = 1'b1;
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      busy_q.push_back(lat);
      issue_q.push_back(cyc);
      name_q.push_back(name);
      last_result = exp;
    end
    @(posedge clk); #1;
    // StartE drops and operands change; the captured op must be unaffected.
    bus.StartE  = 1'b0;
    bus.SrcAE   = $urandom();
    bus.SrcBE   = $urandom();
    bus.funct3E = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input string name, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.DoneE) begin
        done_cyc = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s_timeout: got no DoneE in 100 cycles, expected DoneE", name);
  endtask

  task automatic run(input string name, input logic [2:0] f3,
                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] exp, input int lat);
    int d;
    issue(name, f3, a, b, exp, lat, 1'b1);
    wait_done(name, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   d1, d2;
    logic saw_done;

    reset       = 1'b0;
    bus.FlushE  = 1'b0;
    bus.StartE  = 1'b1;   // BusyE must stay low while in reset
    bus.funct3E = 3'b000;
    bus.SrcAE   = 32'd3;
    bus.SrcBE   = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.ResultE, 32'h0);
    check("reset_done", {31'b0, bus.DoneE}, 32'h0);
    check("reset_busy", {31'b0, bus.BusyE}, 32'h0);
    check("reset_state", {30'b0, dbg_state}, 32'h0);
    bus.StartE = 1'b0;
    reset      = 1'b1;

    // multiply
    run("mul_7_m3",      3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run("mulh_min_min",  3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 33);
    run("mulhu_ff_ff",   3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mulhsu_m1_2",   3'b010, 32'hFFFFFFFF,  32'h00000002, 32'hFFFFFFFF, 33);
    run("mulh_m3_5",     3'b001, 32'hFFFFFFFD,  32'd5,        32'hFFFFFFFF, 33);
    run("mulhu_2p31_2",  3'b011, 32'h80000000,  32'd2,        32'h00000001, 33);
    run("mul_2p16_2p16", 3'b000, 32'h00010000,  32'h00010000, 32'h00000000, 33);

    // divide
    run("div_m7_2",      3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33);
    run("rem_m7_2",      3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33);
    run("divu_100_7",    3'b101, 32'd100,       32'd7,        32'd14,       33);
    run("remu_100_7",    3'b111, 32'd100,       32'd7,        32'd2,        33);
    run("div_20_m3",     3'b100, 32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    run("rem_20_m3",     3'b110, 32'd20,        32'hFFFFFFFD, 32'd2,        33);
    run("rem_m20_3",     3'b110, 32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 33);

    // special divides finish one cycle after capture
    run("divu_by0",      3'b101, 32'h00001234,  32'd0,        32'hFFFFFFFF, 1);
    run("remu_by0",      3'b111, 32'h00001234,  32'd0,        32'h00001234, 1);
    run("div_m7_by0",    3'b100, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF, 1);
    run("rem_m7_by0",    3'b110, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9, 1);
    run("div_ovf",       3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf",       3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1);

    // flush in the middle of an op
    issue("flush_op", 3'b000, 32'd5, 32'd6, 32'd30, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bus.FlushE = 1'b1;
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    check("flush_state_idle", {30'b0, dbg_state}, 32'h0);
    check("flush_result_kept", bus.ResultE, last_result);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.DoneE) saw_done = 1'b1;
    end
    check("flush_no_done", {31'b0, saw_done}, 32'h0);
    run("after_flush_mul", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // reset in the middle of an op
    issue("reset_op", 3'b000, 32'd9, 32'd9, 32'd81, 33, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'b0, bus.BusyE}, 32'h0);
    check("midreset_done", {31'b0, bus.DoneE}, 32'h0);
    check("midreset_result", bus.ResultE, 32'h0);
    check("midreset_state", {30'b0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // back-to-back multiplies: one idle cycle between DONE and the next BUSY
    issue("b2b_1", 3'b000, 32'd6, 32'd7, 32'd42, 33, 1'b1);
    wait_done("b2b_1", d1);
    issue("b2b_2", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 1'b1);
    wait_done("b2b_2", d2);
    check_int("b2b_done_spacing", d2 - d1, 34);

    repeat (3) @(posedge clk);
    #1;
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
